// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared types and helpers for the FFT sequencing blocks.
//   state_t         : controller FSM states
//   SEL_*           : phase-select codes presented to the datapath
//   BITREV_MAXW     : widest address the bit-reverse helper supports
//   bitrev(v, w)    : reverse the low w bits of v (upper result bits zero)
// ---------------------------------------------------------------------------
package fft_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ISSUE  = 3'd2,
    DRAIN  = 3'd3,
    UNLOAD = 3'd4
  } state_t;

  localparam logic [1:0] SEL_IDLE = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_COMP = 2'd2;
  localparam logic [1:0] SEL_UNLD = 2'd3;

  localparam int BITREV_MAXW = 10;

  // Reverse the full BITREV_MAXW-bit word, then shift down so the reversed
  // low 'width' bits land in [width-1:0]. Bits above 'width' in v are
  // expected to be zero; they fall off the bottom during the shift.
  function automatic logic [BITREV_MAXW-1:0] bitrev(
    input logic [BITREV_MAXW-1:0] v,
    input int                     width
  );
    logic [BITREV_MAXW-1:0] r;
    for (int i = 0; i < BITREV_MAXW; i++) begin
      r[BITREV_MAXW-1-i] = v[i];
    end
    return r >> (BITREV_MAXW - width);
  endfunction

endpackage

// File: rtl/fft_ctrl_param_if.sv
// ---------------------------------------------------------------------------
// fft_ctrl_param_if
// Bundles the sample-side handshake and the datapath control bus of the FFT
// controller.
//   master : the controller (drives busy/SEL/addresses/strobes, receives
//            start, in_valid, out_ready)
//   slave  : the surrounding system (sample source/sink plus datapath)
// ---------------------------------------------------------------------------
interface fft_ctrl_param_if #(
  parameter int LOG2N = 5
) ();

  logic             start;
  logic             in_valid;
  logic             out_ready;
  logic             busy;
  logic [1:0]       SEL;
  logic [LOG2N-1:0] enable;
  logic             load_we;
  logic [LOG2N-1:0] load_addr;
  logic             bf_issue;
  logic [LOG2N-1:0] addr_a;
  logic [LOG2N-1:0] addr_b;
  logic [LOG2N-2:0] tw_addr;
  logic             wb_we;
  logic [LOG2N-1:0] wb_addr_a;
  logic [LOG2N-1:0] wb_addr_b;
  logic             out_valid;
  logic [LOG2N-1:0] out_addr;
  logic             done;

  modport master (
    input  start, in_valid, out_ready,
    output busy, SEL, enable, load_we, load_addr,
    output bf_issue, addr_a, addr_b, tw_addr,
    output wb_we, wb_addr_a, wb_addr_b,
    output out_valid, out_addr, done
  );

  modport slave (
    output start, in_valid, out_ready,
    input  busy, SEL, enable, load_we, load_addr,
    input  bf_issue, addr_a, addr_b, tw_addr,
    input  wb_we, wb_addr_a, wb_addr_b,
    input  out_valid, out_addr, done
  );

endinterface

// File: rtl/fft_addr_gen.sv
// ---------------------------------------------------------------------------
// fft_addr_gen
// Combinational radix-2 DIT butterfly address generator.
//   s       in  : stage index, 0..LOG2N-1
//   k       in  : butterfly index within the stage, 0..N/2-1
//   addr_a  out : upper operand address = grp*2*half + pos
//   addr_b  out : lower operand address = addr_a + half
//   tw_addr out : twiddle index         = pos << (LOG2N-1-s)
// with half = 2**s, pos = k mod half, grp = k div half.
// ---------------------------------------------------------------------------
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N = 5,
  parameter int SW    = $clog2(LOG2N)
) (
  input  logic [SW-1:0]    s,
  input  logic [LOG2N-1:0] k,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_addr
);

  logic [LOG2N-1:0] half;
  logic [LOG2N-1:0] pos;
  logic [LOG2N-1:0] grp;

  always_comb begin
    half = LOG2N'(1) << s;
    pos  = k & (half - LOG2N'(1));
    grp  = k >> s;
    // Shift in two steps: s+1 can overflow the SW-bit stage field.
    addr_a = ((grp << s) << 1) | pos;
    // Bit s of addr_a is always clear, so OR is the same as adding half.
    addr_b = addr_a | half;
    // pos < 2**s, so the shifted value always fits in LOG2N-1 bits.
    tw_addr = (LOG2N-1)'(pos << (LOG2N - 1 - int'(s)));
  end

endmodule

// File: rtl/fft_ctrl_param.sv
// ---------------------------------------------------------------------------
// fft_ctrl_param
// Frame sequencer for a radix-2 DIT FFT of N = 2**LOG2N points sharing one
// butterfly/memory datapath. A frame runs bit-reversed LOAD, LOG2N stages of
// ISSUE (N/2 butterflies) + DRAIN (BF_LAT idle cycles), then in-order UNLOAD.
//   clk_100 in : system clock, rising edge
//   rst     in : synchronous active-high reset
//   bus     -- : fft_ctrl_param_if.master
//                 start/in_valid/out_ready in; busy, SEL, enable, load_we,
//                 load_addr, bf_issue, addr_a/b, tw_addr, wb_we,
//                 wb_addr_a/b, out_valid, out_addr, done out
// Outputs are flops loaded from the next-state values, so each output
// describes the state the controller is in during that cycle. load_we is the
// one exception: it is in_valid gated by the registered LOAD state, since it
// must follow the sample strobe in the same cycle.
// ---------------------------------------------------------------------------
module fft_ctrl_param
  import fft_pkg::*;
#(
  parameter int LOG2N  = 5,
  parameter int BF_LAT = 2
) (
  input  logic             clk_100,
  input  logic             rst,
  fft_ctrl_param_if.master bus
);

  localparam int N  = 1 << LOG2N;
  localparam int SW = $clog2(LOG2N);
  localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam int PW = 1 + 2 * LOG2N;

  localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] K_LAST   = LOG2N'(N / 2 - 1);
  localparam logic [SW-1:0]    S_LAST   = SW'(LOG2N - 1);
  localparam logic [DW-1:0]    D_LAST   = DW'(BF_LAT - 1);

  // FSM and counters. cnt is shared by LOAD and UNLOAD; they never overlap.
  state_t           state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic [LOG2N-1:0] k_q, k_d;
  logic [SW-1:0]    s_q, s_d;
  logic [DW-1:0]    dr_q, dr_d;

  // Registered outputs.
  logic             busy_q, busy_d;
  logic [1:0]       sel_q, sel_d;
  logic [LOG2N-1:0] enable_q, enable_d;
  logic [LOG2N-1:0] load_addr_q, load_addr_d;
  logic             bf_issue_q, bf_issue_d;
  logic [LOG2N-1:0] addr_a_q, addr_a_d;
  logic [LOG2N-1:0] addr_b_q, addr_b_d;
  logic [LOG2N-2:0] tw_addr_q, tw_addr_d;
  logic             out_valid_q, out_valid_d;
  logic [LOG2N-1:0] out_addr_q, out_addr_d;
  logic             done_q, done_d;

  // Butterfly addresses for the (stage, k) pair about to be presented.
  logic [LOG2N-1:0] gen_a;
  logic [LOG2N-1:0] gen_b;
  logic [LOG2N-2:0] gen_tw;

  fft_addr_gen #(
    .LOG2N (LOG2N),
    .SW    (SW)
  ) u_addr_gen (
    .s       (s_d),
    .k       (k_d),
    .addr_a  (gen_a),
    .addr_b  (gen_b),
    .tw_addr (gen_tw)
  );

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    s_d     = s_q;
    dr_d    = dr_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end

      LOAD: begin
        if (bus.in_valid) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ISSUE;
            cnt_d   = '0;
            s_d     = '0;
            k_d     = '0;
          end else begin
            cnt_d = cnt_q + LOG2N'(1);
          end
        end
      end

      ISSUE: begin
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          k_d     = '0;
          dr_d    = '0;
        end else begin
          k_d = k_q + LOG2N'(1);
        end
      end

      // Hold off the next stage until the last write-back of this one has
      // left the butterfly pipeline.
      DRAIN: begin
        if (dr_q == D_LAST) begin
          dr_d = '0;
          if (s_q == S_LAST) begin
            state_d = UNLOAD;
            s_d     = '0;
            cnt_d   = '0;
          end else begin
            state_d = ISSUE;
            s_d     = s_q + SW'(1);
            k_d     = '0;
          end
        end else begin
          dr_d = dr_q + DW'(1);
        end
      end

      UNLOAD: begin
        if (bus.out_ready) begin
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + LOG2N'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode from the next state (loaded into the output flops)
  // -------------------------------------------------------------------------
  always_comb begin
    busy_d      = (state_d != IDLE);
    sel_d       = SEL_IDLE;
    enable_d    = '0;
    load_addr_d = '0;
    bf_issue_d  = 1'b0;
    addr_a_d    = '0;
    addr_b_d    = '0;
    tw_addr_d   = '0;
    out_valid_d = 1'b0;
    out_addr_d  = '0;

    case (state_d)
      LOAD: begin
        sel_d       = SEL_LOAD;
        load_addr_d = LOG2N'(bitrev(BITREV_MAXW'(cnt_d), LOG2N));
      end
      ISSUE: begin
        sel_d      = SEL_COMP;
        enable_d   = LOG2N'(1) << s_d;
        bf_issue_d = 1'b1;
        addr_a_d   = gen_a;
        addr_b_d   = gen_b;
        tw_addr_d  = gen_tw;
      end
      DRAIN: begin
        sel_d    = SEL_COMP;
        enable_d = LOG2N'(1) << s_d;
      end
      UNLOAD: begin
        sel_d       = SEL_UNLD;
        out_valid_d = 1'b1;
        out_addr_d  = cnt_d;
      end
      default: begin
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Write-back delay line: stage 0 captures the issued butterfly, the last
  // stage is the write-back strobe, BF_LAT cycles after bf_issue.
  // -------------------------------------------------------------------------
  logic [BF_LAT-1:0][PW-1:0] wb_pipe_q;
  logic [BF_LAT-1:0][PW-1:0] wb_pipe_d;

  assign wb_pipe_d[0] = {bf_issue_q, addr_a_q, addr_b_q};

  for (genvar gi = 1; gi < BF_LAT; gi++) begin : g_wb_pipe
    assign wb_pipe_d[gi] = wb_pipe_q[gi-1];
  end

  // -------------------------------------------------------------------------
  // State, counter, output and delay-line registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      s_q         <= '0;
      dr_q        <= '0;
      busy_q      <= 1'b0;
      sel_q       <= SEL_IDLE;
      enable_q    <= '0;
      load_addr_q <= '0;
      bf_issue_q  <= 1'b0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      tw_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      done_q      <= 1'b0;
      wb_pipe_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      s_q         <= s_d;
      dr_q        <= dr_d;
      busy_q      <= busy_d;
      sel_q       <= sel_d;
      enable_q    <= enable_d;
      load_addr_q <= load_addr_d;
      bf_issue_q  <= bf_issue_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      tw_addr_q   <= tw_addr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      done_q      <= done_d;
      wb_pipe_q   <= wb_pipe_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.SEL       = sel_q;
  assign bus.enable    = enable_q;
  assign bus.load_we   = bus.in_valid & (state_q == LOAD);
  assign bus.load_addr = load_addr_q;
  assign bus.bf_issue  = bf_issue_q;
  assign bus.addr_a    = addr_a_q;
  assign bus.addr_b    = addr_b_q;
  assign bus.tw_addr   = tw_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.done      = done_q;
  assign {bus.wb_we, bus.wb_addr_a, bus.wb_addr_b} = wb_pipe_q[BF_LAT-1];

endmodule

// File: doc/fft_ctrl_param.md
Name: fft_ctrl_param

Overview:
- Parametrised successor to the fixed 32-point FFT Control_unit.
- Sequences one radix-2 DIT FFT frame of N = 2**LOG2N points through four phases: bit-reversed load, LOG2N butterfly stages, drain, and in-order unload.
- Drives the datapath's stage enables, phase select, butterfly/twiddle addresses and delayed write-back strobes.
- Sits between the sample interface and the shared butterfly/memory datapath.

Parameters:
- LOG2N, 5, log2 of FFT size; legal range 2..10; N = 2**LOG2N.
- BF_LAT, 2, butterfly pipeline latency in cycles (issue to write-back); legal range 1..8.

Ports:
- clk_100  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- in_valid  in  1  input sample present this cycle (LOAD only).
- out_ready  in  1  downstream accepts output sample this cycle (UNLOAD only).
- busy  out  1  high in every state except IDLE.
- SEL  out  2  phase select: 0 idle, 1 load, 2 compute, 3 unload.
- enable  out  LOG2N  one-hot active-stage enable; 0 outside COMPUTE.
- load_we  out  1  equals in_valid while in LOAD.
- load_addr  out  LOG2N  bit-reversed load counter.
- bf_issue  out  1  butterfly issue strobe.
- addr_a  out  LOG2N  butterfly upper operand address.
- addr_b  out  LOG2N  butterfly lower operand address.
- tw_addr  out  LOG2N-1  twiddle ROM address.
- wb_we  out  1  write-back strobe (bf_issue delayed BF_LAT).
- wb_addr_a  out  LOG2N  addr_a delayed BF_LAT.
- wb_addr_b  out  LOG2N  addr_b delayed BF_LAT.
- out_valid  out  1  output sample valid.
- out_addr  out  LOG2N  natural-order read address.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- All outputs are registered.
- Reset: state IDLE; every output and counter 0, including the BF_LAT delay line.
- rst has priority over all other inputs in every state. Asserted mid-frame, the next cycle is IDLE with all outputs 0; no partial write-back escapes.
- IDLE:
  - start=1 moves to LOAD next cycle; SEL becomes 1.
  - start in any other state is ignored, with no queuing.
- LOAD:
  - cnt advances only on in_valid; load_addr = bitrev(cnt); load_we = in_valid.
  - After the N-th accepted sample, go to COMPUTE with s=0, k=0.
- COMPUTE, per stage s (0..LOG2N-1):
  - ISSUE: N/2 consecutive cycles, bf_issue=1, k = 0..N/2-1.
  - DRAIN: BF_LAT cycles, bf_issue=0, so stage s+1 never reads before stage s write-back completes.
  - enable[s]=1 throughout ISSUE and DRAIN of stage s.
  - Address rule, with half = 2**s, pos = k mod half, grp = k div half:
    - addr_a = grp*2*half + pos
    - addr_b = addr_a + half
    - tw_addr = pos << (LOG2N-1-s)
  - After DRAIN of stage LOG2N-1, go to UNLOAD.
  - Total COMPUTE cycles = LOG2N*(N/2+BF_LAT).
- Write-back: a BF_LAT-deep shift register carries {bf_issue, addr_a, addr_b} to {wb_we, wb_addr_a, wb_addr_b}.
- UNLOAD:
  - out_valid=1; out_addr holds its value until out_ready=1, then increments.
  - After address N-1 is accepted: go to IDLE, done=1 for exactly one cycle, busy=0 in that same cycle.
- Wrap-around: counters are exactly LOG2N bits wide; terminal counts are detected explicitly, never by overflow.

Decomposition:
- Package fft_pkg holds:
  - state enum (IDLE, LOAD, ISSUE, DRAIN, UNLOAD);
  - SEL codes SEL_IDLE/SEL_LOAD/SEL_COMP/SEL_UNLD;
  - bitrev function parametrised by width.
- Sub-module fft_addr_gen: combinational (s, k) -> addr_a, addr_b, tw_addr. It is reused by the future streaming FFT.
- The delay line stays inline.

Test Plan (LOG2N=5, BF_LAT=2 unless noted):
1. Hold rst 3 cycles -> SEL=0, enable=0, busy=0, done=0, all addresses 0.
2. Pulse start, then 32 in_valid with 5 random gaps -> load_addr sequence 0,16,8,24,4,20,...,31; held during gaps; SEL=2, enable=00001 one cycle after the 32nd accept.
3. Compute addressing:
   - stage 0: addr_a=0,2,...,30; addr_b=1,...,31; tw_addr=0.
   - stage 2: first issues a/b = 0/4, 1/5, 2/6, 3/7, 8/12; tw = 0,4,8,12,0.
   - stage 4: a=0..15, b=16..31, tw=0..15.
   - enable walks 00001 -> 10000.
4. Write-back timing: wb_we exactly 2 cycles after each bf_issue with matching addresses; 80 wb_we pulses; COMPUTE lasts 90 cycles. Repeat with BF_LAT=5 -> 105 cycles.
5. UNLOAD with out_ready toggling 1,0,0,1 -> out_addr advances only on out_ready; done pulses once, coincident with the IDLE entry cycle.
6. Robustness:
   - start during COMPUTE -> no effect.
   - rst at stage 2, k=7 -> next cycle IDLE, all outputs 0, no wb_we afterwards.
   - New start -> full clean frame.
   - LOG2N=2 -> 2 stages of 2 issues each.
